// File: rtl/case_4_mul_share_arbiter.sv
// Round-robin arbiter sharing one pipelined signed multiplier among NUM_REQ requesters.
// Results leave the final pipeline stage tagged with the index of the requester that issued them.
module case_4_mul_share_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DIN0_WIDTH = 6,
  parameter int DIN1_WIDTH = 6,
  parameter int DOUT_WIDTH = 6,
  parameter int NUM_STAGE  = 2,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           ap_clk,
  input  logic                           ap_rst,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*DIN0_WIDTH-1:0]  req_din0,
  input  logic [NUM_REQ*DIN1_WIDTH-1:0]  req_din1,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DOUT_WIDTH-1:0]          rsp_dout,
  output logic                           idle
);

  logic [ID_WIDTH-1:0]          rrPtr_q, rrPtr_d;
  logic [NUM_STAGE-1:0]         vld_q, vld_d;
  logic [ID_WIDTH-1:0]          id_q   [NUM_STAGE];
  logic [ID_WIDTH-1:0]          id_d   [NUM_STAGE];
  logic [DOUT_WIDTH-1:0]        dout_q [NUM_STAGE];
  logic [DOUT_WIDTH-1:0]        dout_d [NUM_STAGE];

  logic                         stall;
  logic                         candFound;
  logic                         accept;
  logic [ID_WIDTH-1:0]          candIdx;
  logic signed [DIN0_WIDTH-1:0] selDin0;
  logic signed [DIN1_WIDTH-1:0] selDin1;
  logic signed [DOUT_WIDTH-1:0] opA, opB, prodLow;

  assign stall = vld_q[NUM_STAGE-1] & ~rsp_ready;

  // First valid requester after the last winner, wrapping around.
  always_comb begin
    candFound = 1'b0;
    candIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!candFound && req_valid[(int'(rrPtr_q) + k) % NUM_REQ]) begin
        candFound = 1'b1;
        candIdx   = ID_WIDTH'((int'(rrPtr_q) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (candFound && (candIdx == ID_WIDTH'(i))) begin
        req_ready[i] = ~stall & ~ap_rst;
      end
    end
  end

  assign accept  = candFound & ~stall & ~ap_rst;
  assign selDin0 = req_din0[int'(candIdx)*DIN0_WIDTH +: DIN0_WIDTH];
  assign selDin1 = req_din1[int'(candIdx)*DIN1_WIDTH +: DIN1_WIDTH];

  // Low bits of a product depend only on low operand bits, so multiplying at
  // DOUT_WIDTH after sign extension/truncation yields the truncated full product.
  assign opA     = DOUT_WIDTH'(selDin0);
  assign opB     = DOUT_WIDTH'(selDin1);
  assign prodLow = opA * opB;

  always_comb begin
    rrPtr_d = rrPtr_q;
    vld_d   = vld_q;
    id_d    = id_q;
    dout_d  = dout_q;
    if (!stall) begin
      for (int s = NUM_STAGE - 1; s > 0; s--) begin
        vld_d[s]  = vld_q[s-1];
        id_d[s]   = id_q[s-1];
        dout_d[s] = dout_q[s-1];
      end
      vld_d[0]  = accept;
      id_d[0]   = accept ? candIdx : '0;
      dout_d[0] = accept ? prodLow : '0;
      if (accept) begin
        rrPtr_d = candIdx;
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      rrPtr_q <= ID_WIDTH'(NUM_REQ - 1);
      vld_q   <= '0;
      for (int s = 0; s < NUM_STAGE; s++) begin
        id_q[s]   <= '0;
        dout_q[s] <= '0;
      end
    end else begin
      rrPtr_q <= rrPtr_d;
      vld_q   <= vld_d;
      for (int s = 0; s < NUM_STAGE; s++) begin
        id_q[s]   <= id_d[s];
        dout_q[s] <= dout_d[s];
      end
    end
  end

  assign rsp_valid = vld_q[NUM_STAGE-1];
  assign rsp_id    = id_q[NUM_STAGE-1];
  assign rsp_dout  = dout_q[NUM_STAGE-1];
  assign idle      = ~(|vld_q);

endmodule

// File: tb/tb_case_4_mul_share_arbiter.sv
// Directed bench for case_4_mul_share_arbiter: single-transaction vector table plus
// hand-written round-robin, stall, fairness and mid-flight reset sequences.
module tb_case_4_mul_share_arbiter;

  logic        ap_clk;
  logic        ap_rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [23:0] req_din0;
  logic [23:0] req_din1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [5:0]  rsp_dout;
  logic        idle;

  int checks = 0;
  int fails  = 0;

  logic [5:0] din0Arr [4];
  logic [5:0] din1Arr [4];
  logic [5:0] expProd [4];

  typedef struct {
    logic [1:0] rid;
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] expDout;
  } vec_t;

  vec_t vecs [7];
  int   order [6];

  case_4_mul_share_arbiter #(
    .NUM_REQ(4), .DIN0_WIDTH(6), .DIN1_WIDTH(6),
    .DOUT_WIDTH(6), .NUM_STAGE(2), .ID_WIDTH(2)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_din0(req_din0), .req_din1(req_din1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_dout(rsp_dout),
    .idle(idle)
  );

  initial ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  initial begin
    #50000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] valid, input logic rdy);
    req_valid = valid;
    rsp_ready = rdy;
    for (int i = 0; i < 4; i++) begin
      req_din0[i*6 +: 6] = din0Arr[i];
      req_din1[i*6 +: 6] = din1Arr[i];
    end
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkRsp(input string name, input int id);
    checkOutput({name, " valid"}, 32'(rsp_valid), 32'd1);
    checkOutput({name, " id"},    32'(rsp_id),    32'(id));
    checkOutput({name, " dout"},  32'(rsp_dout),  32'(expProd[id]));
  endtask

  task automatic resetDut();
    ap_rst = 1'b1;
    applyStimulus(4'h0, 1'b1);
    tick();
    ap_rst = 1'b0;
  endtask

  initial begin
    // -3*5=-15, 31*31=961, -32*-32=1024, -32*1, -1*-1, 7*9=63, -22*3=-66, all mod 64
    vecs[0] = '{2'd0, 6'h3D, 6'h05, 6'h31};
    vecs[1] = '{2'd0, 6'h1F, 6'h1F, 6'h01};
    vecs[2] = '{2'd0, 6'h20, 6'h20, 6'h00};
    vecs[3] = '{2'd0, 6'h20, 6'h01, 6'h20};
    vecs[4] = '{2'd1, 6'h3F, 6'h3F, 6'h01};
    vecs[5] = '{2'd2, 6'h07, 6'h09, 6'h3F};
    vecs[6] = '{2'd3, 6'h2A, 6'h03, 6'h3E};
    order   = '{0, 1, 2, 3, 0, 1};
    for (int i = 0; i < 4; i++) begin
      din0Arr[i] = 6'h00;
      din1Arr[i] = 6'h00;
    end

    // Reset held for two edges with all requests raised: no grant may leak out.
    ap_rst = 1'b1;
    applyStimulus(4'hF, 1'b1);
    tick();
    checkOutput("ready during reset", 32'(req_ready), 32'h0);
    tick();
    ap_rst = 1'b0;
    checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("reset rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("reset rsp_dout",  32'(rsp_dout),  32'd0);
    checkOutput("reset idle",      32'(idle),      32'd1);

    for (int v = 0; v < 7; v++) begin
      din0Arr[vecs[v].rid] = vecs[v].a;
      din1Arr[vecs[v].rid] = vecs[v].b;
      applyStimulus(4'b0001 << vecs[v].rid, 1'b1);
      checkOutput("vec ready", 32'(req_ready), 32'(4'b0001 << vecs[v].rid));
      tick();
      applyStimulus(4'h0, 1'b1);
      checkOutput("vec early valid", 32'(rsp_valid), 32'd0);
      checkOutput("vec busy idle",   32'(idle),      32'd0);
      tick();
      checkOutput("vec rsp_valid", 32'(rsp_valid), 32'd1);
      checkOutput("vec rsp_id",    32'(rsp_id),    32'(vecs[v].rid));
      checkOutput("vec rsp_dout",  32'(rsp_dout),  32'(vecs[v].expDout));
      tick();
      checkOutput("vec drained valid", 32'(rsp_valid), 32'd0);
      checkOutput("vec drained idle",  32'(idle),      32'd1);
    end

    // Distinct operands per requester: 2*3=6, -2*5=-10, 31*2=62, -3*-3=9.
    din0Arr[0] = 6'h02; din1Arr[0] = 6'h03; expProd[0] = 6'h06;
    din0Arr[1] = 6'h3E; din1Arr[1] = 6'h05; expProd[1] = 6'h36;
    din0Arr[2] = 6'h1F; din1Arr[2] = 6'h02; expProd[2] = 6'h3E;
    din0Arr[3] = 6'h3D; din1Arr[3] = 6'h3D; expProd[3] = 6'h09;

    resetDut();
    applyStimulus(4'hF, 1'b1);
    for (int c = 0; c < 6; c++) begin
      checkOutput("rr grant", 32'(req_ready), 32'(4'b0001 << order[c]));
      tick();
      if (c == 5) applyStimulus(4'h0, 1'b1);
      if (c == 0) checkOutput("rr first latency", 32'(rsp_valid), 32'd0);
      else        checkRsp("rr rsp", order[c-1]);
    end
    tick();
    checkRsp("rr last rsp", order[5]);
    tick();
    checkOutput("rr drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("rr drained idle",  32'(idle),      32'd1);

    // Backpressure for three edges while two results are in flight.
    resetDut();
    applyStimulus(4'hF, 1'b1);
    checkOutput("stall pre grant0", 32'(req_ready), 32'h1);
    tick();
    checkOutput("stall pre valid", 32'(rsp_valid), 32'd0);
    checkOutput("stall pre grant1", 32'(req_ready), 32'h2);
    tick();
    checkRsp("stall first rsp", 0);
    applyStimulus(4'hF, 1'b0);
    for (int s = 0; s < 3; s++) begin
      checkOutput("stall ready", 32'(req_ready), 32'h0);
      checkRsp("stall hold", 0);
      tick();
    end
    checkRsp("stall hold end", 0);
    applyStimulus(4'hF, 1'b1);
    checkOutput("stall release grant", 32'(req_ready), 32'h4);
    tick();
    checkRsp("stall resume rsp1", 1);
    checkOutput("stall resume grant", 32'(req_ready), 32'h8);
    tick();
    applyStimulus(4'h0, 1'b1);
    checkRsp("stall resume rsp2", 2);
    tick();
    checkRsp("stall resume rsp3", 3);
    tick();
    checkOutput("stall drained valid", 32'(rsp_valid), 32'd0);
    checkOutput("stall drained idle",  32'(idle),      32'd1);

    // Requesters 1 and 3, then requester 0 must overtake a repeat of 3.
    resetDut();
    applyStimulus(4'b1010, 1'b1);
    checkOutput("fair grant1", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'b1000, 1'b1);
    checkOutput("fair grant3", 32'(req_ready), 32'h8);
    tick();
    checkRsp("fair rsp1", 1);
    applyStimulus(4'b1001, 1'b1);
    checkOutput("fair grant0", 32'(req_ready), 32'h1);
    tick();
    checkRsp("fair rsp3", 3);
    checkOutput("fair grant3 again", 32'(req_ready), 32'h8);
    tick();
    applyStimulus(4'h0, 1'b1);
    checkRsp("fair rsp0", 0);
    tick();
    checkRsp("fair rsp3 again", 3);
    tick();
    checkOutput("fair drained idle", 32'(idle), 32'd1);

    // Reset with two operations in flight; pointer left at 1 beforehand.
    resetDut();
    applyStimulus(4'b0001, 1'b1);
    checkOutput("flush grant0", 32'(req_ready), 32'h1);
    tick();
    applyStimulus(4'b0010, 1'b0);
    checkOutput("flush grant1", 32'(req_ready), 32'h2);
    tick();
    checkRsp("flush visible", 0);
    ap_rst = 1'b1;
    #1;
    checkOutput("flush ready in reset", 32'(req_ready), 32'h0);
    tick();
    ap_rst = 1'b0;
    checkOutput("flush rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("flush idle",      32'(idle),      32'd1);
    checkOutput("flush rsp_id",    32'(rsp_id),    32'd0);
    checkOutput("flush rsp_dout",  32'(rsp_dout),  32'd0);
    applyStimulus(4'b0110, 1'b1);
    checkOutput("flush first grant", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(4'h0, 1'b1);
    checkOutput("flush no stale rsp", 32'(rsp_valid), 32'd0);
    tick();
    checkRsp("flush new rsp", 1);
    tick();
    checkOutput("flush end valid", 32'(rsp_valid), 32'd0);
    checkOutput("flush end idle",  32'(idle),      32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/case_4_mul_share_arbiter.md
Name: case_4_mul_share_arbiter

Overview:
- Shares one pipelined signed multiplier among NUM_REQ requesters using round-robin arbitration.
- The multiplier follows the case_4 signed multiply convention: both operands are signed, and the product is truncated to DOUT_WIDTH LSBs.
- The block sits between the HLS loop bodies, which issue multiply requests, and the single multiplier resource.
- Results return tagged with the requester index.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DIN0_WIDTH, 6, operand 0 width, signed.
- DIN1_WIDTH, 6, operand 1 width, signed.
- DOUT_WIDTH, 6, product width. Result is the low DOUT_WIDTH bits of the full signed product.
- NUM_STAGE, 2, multiplier pipeline depth (>=1). This is the accept-to-response latency in cycles.
- ID_WIDTH, 2, width of the requester tag. Must satisfy 2^ID_WIDTH >= NUM_REQ.

Ports:
- ap_clk  in  1  clock; all logic is on the rising edge.
- ap_rst  in  1  synchronous reset, active-high.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit is high.
- req_din0  in  NUM_REQ*DIN0_WIDTH  flattened operand 0; requester i occupies bits [i*DIN0_WIDTH +: DIN0_WIDTH].
- req_din1  in  NUM_REQ*DIN1_WIDTH  flattened operand 1, same packing.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  downstream accepts the result.
- rsp_id  out  ID_WIDTH  index of the requester that owns the result.
- rsp_dout  out  DOUT_WIDTH  signed product, truncated.
- idle  out  1  high when no pipeline stage holds a valid entry.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - All stage valid bits clear; in-flight operations are discarded, with no response.
  - rsp_valid=0, rsp_id=0, rsp_dout=0, idle=1.
  - rr_ptr=NUM_REQ-1, so requester 0 has highest priority after reset.
  - req_ready=0 while ap_rst is high.
- Stall:
  - stall = rsp_valid & ~rsp_ready.
  - While stall=1, every pipeline stage, rsp_id and rsp_dout hold their values, and req_ready=0 on all lines.
- Arbitration (combinational):
  - Candidate = first i with req_valid[i]=1, searching from (rr_ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[candidate] = ~stall & ~ap_rst.
  - req_ready may depend combinationally on req_valid.
  - No candidate: req_ready all 0, and a bubble enters stage 1.
- Accept:
  - Occurs when req_valid[i] & req_ready[i] at an edge.
  - Stage 1 captures din0[i], din1[i], tag i and valid=1.
  - rr_ptr <= i.
  - rr_ptr changes only on an accept.
- Pipeline:
  - Advances one stage per cycle when stall=0.
  - Bubbles are not collapsed.
  - The product is computed as signed(din0) * signed(din1) at full width (DIN0_WIDTH+DIN1_WIDTH), then truncated to the low DOUT_WIDTH bits.
  - The product may be registered in any stage; the result must appear only at the final stage.
- Latency:
  - An accept at edge t makes rsp_valid=1 after edge t+NUM_STAGE-1, so the response is visible in the cycle following edge t+NUM_STAGE-1.
  - This holds with no stall; each stall cycle adds exactly one cycle.
- Throughput: one accept per cycle when rsp_ready is held at 1.
- Outputs: rsp_valid, rsp_id and rsp_dout are driven from final-stage registers, with no combinational path from inputs.
- Ordering: responses leave in accept order. No response is dropped or duplicated except when reset is applied.
- Fairness: a continuously asserted request is granted within NUM_REQ accepts.
- Requester contract: after asserting req_valid[i], the requester must hold req_valid and its operands until accepted. The block does not check this.
- idle = ~(OR of all stage valid bits), registered-state derived.

Test Plan:
- Requester 0 alone, din0=6'h3D (-3), din1=6'h05, rsp_ready=1 -> with NUM_STAGE=2, rsp_valid=1 two cycles after the accept; rsp_id=0, rsp_dout=6'h31 (-15); idle returns to 1 afterwards.
- Truncation cases:
  - din0=6'h1F, din1=6'h1F -> rsp_dout=6'h01 (961 mod 64).
  - din0=6'h20, din1=6'h20 -> 6'h00.
  - din0=6'h20, din1=6'h01 -> 6'h20.
- All 4 requesters held valid with distinct operands, rsp_ready=1 -> grant order 0,1,2,3,0,1; one response per cycle; rsp_id sequence matches the grant order; products correct.
- Responses streaming, rsp_ready dropped for 3 cycles -> rsp_valid, rsp_id and rsp_dout hold stable; req_ready=0 throughout; after release the pipeline resumes with no lost or duplicated result and order preserved.
- Requesters 1 and 3 valid, then 1 drops after its grant -> 3 granted next; rr_ptr=3; a new request from requester 0 is granted before requester 3 is granted again.
- ap_rst asserted for 1 cycle with 2 operations in flight -> next cycle rsp_valid=0 and idle=1; in-flight results are never emitted; the first grant after reset goes to the lowest valid index.
